// File: rtl/iics.sv
// I2C register-slave front end: write path always present; read path enabled by IICS_READ_EN.
// SCL/SDA are resynchronised to clk; all bus events are decoded from the synchronised lines.
module iics #(
    parameter logic [7:0] CHIP_ADDR = 8'hD0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_is_out,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    input  logic [7:0] rd_data,
    output logic       rd_en,
    output logic       busy
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    // Two-flop synchronisers plus one delay stage per line for edge detection
    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c;
    assign scl_rise = scl_s2 & ~scl_d;
    assign scl_fall = ~scl_s2 & scl_d;
    assign start_c  = scl_s2 & scl_d & ~sda_s2 & sda_d;
    assign stop_c   = scl_s2 & scl_d & sda_s2 & ~sda_d;

    state_t          state, state_n;
    logic [CW-1:0]   bit_cnt, bit_cnt_n;
    logic [DW-2:0]   shift, shift_n;
    logic [DW-1:0]   ptr, ptr_n;
    logic            sda_o_n, oe_n, wr_en_n, busy_n;
    logic [DW-1:0]   wr_addr_n, wr_data_n;

    logic [DW-1:0]   rx_byte;
    logic            byte_done, addr_hit;
    assign rx_byte   = {shift, sda_s2};
    assign byte_done = scl_rise && (bit_cnt == LAST_BIT);

`ifdef IICS_READ_EN
    logic            rw, rw_n, rd_en_n;
    logic [DW-1:0]   tx, tx_n;
    assign addr_hit = (rx_byte[DW-1:1] == CHIP_ADDR[DW-1:1]);
`else
    // Reads are not supported: a read request looks like a foreign address
    logic unused_rd;
    assign unused_rd = ^rd_data;
    assign addr_hit  = (rx_byte[DW-1:1] == CHIP_ADDR[DW-1:1]) && !rx_byte[0];
    assign rd_en     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            ptr        <= '0;
            sda_o      <= 1'b1;
            sda_is_out <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
`ifdef IICS_READ_EN
            rw         <= 1'b0;
            rd_en      <= 1'b0;
            tx         <= '0;
`endif
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            ptr        <= ptr_n;
            sda_o      <= sda_o_n;
            sda_is_out <= oe_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            busy       <= busy_n;
`ifdef IICS_READ_EN
            rw         <= rw_n;
            rd_en      <= rd_en_n;
            tx         <= tx_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ptr_n     = ptr;
        sda_o_n   = sda_o;
        oe_n      = sda_is_out;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
`ifdef IICS_READ_EN
        rd_en_n   = 1'b0;
        rw_n      = rw;
        tx_n      = rd_en ? rd_data : tx;
`endif
        if (scl_rise) begin
            shift_n   = rx_byte[DW-2:0];
            bit_cnt_n = bit_cnt + CW'(1);
        end

        if (stop_c) begin
            state_n = IDLE;
            sda_o_n = 1'b1;
            oe_n    = 1'b0;
        end else if (start_c) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_o_n   = 1'b1;
            oe_n      = 1'b0;
        end else begin
            case (state)
                IDLE, IGNORE: begin
                    sda_o_n = 1'b1;
                    oe_n    = 1'b0;
                end
                ADDR: begin
                    if (byte_done) begin
                        if (addr_hit) begin
                            state_n = ACK_A;
`ifdef IICS_READ_EN
                            rw_n    = rx_byte[0];
                            rd_en_n = rx_byte[0];
`endif
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                REG: begin
                    if (byte_done) begin
                        ptr_n   = rx_byte;
                        state_n = ACK_R;
                    end
                end
                DATA: begin
                    if (byte_done) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = ptr;
                        wr_data_n = rx_byte;
                        ptr_n     = ptr + DW'(1);
                        state_n   = ACK_D;
                    end
                end
                // First SCL fall starts the ACK low, the next one ends it
                ACK_A, ACK_R, ACK_D: begin
                    if (scl_fall) begin
                        if (!sda_is_out) begin
                            oe_n    = 1'b1;
                            sda_o_n = 1'b0;
                        end else begin
                            oe_n      = 1'b0;
                            sda_o_n   = 1'b1;
                            bit_cnt_n = '0;
                            state_n   = (state == ACK_A) ? REG : DATA;
`ifdef IICS_READ_EN
                            if (state == ACK_A && rw) begin
                                state_n = RD_BYTE;
                                oe_n    = 1'b1;
                                sda_o_n = tx[DW-1];
                            end
`endif
                        end
                    end
                end
`ifdef IICS_READ_EN
                RD_BYTE: begin
                    if (scl_rise && bit_cnt == LAST_BIT) begin
                        state_n = RD_ACK;
                    end else if (scl_fall) begin
                        if (!sda_is_out) begin
                            oe_n    = 1'b1;
                            sda_o_n = tx[DW-1];
                        end else begin
                            tx_n    = {tx[DW-2:0], 1'b0};
                            sda_o_n = tx[DW-2];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_fall && sda_is_out) begin
                        oe_n    = 1'b0;
                        sda_o_n = 1'b1;
                    end else if (scl_rise) begin
                        bit_cnt_n = '0;
                        if (!sda_s2) begin
                            ptr_n   = ptr + DW'(1);
                            rd_en_n = 1'b1;
                            state_n = RD_BYTE;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_iics.sv
// Bench for iics: bus-level I2C master, byte-level reference model and strobe scoreboard.
// Read-path scenarios follow IICS_READ_EN.
module tb_iics;

    logic       clk = 1'b0;
    logic       rstn;
    logic       scl_m, sda_m;
    logic       sda_o, sda_is_out, wr_en, rd_en, busy;
    logic [7:0] wr_addr, wr_data, rd_data;
    wire        sda_line = sda_m & (sda_is_out ? sda_o : 1'b1);

    iics #(.CHIP_ADDR(8'hD0)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_o     (sda_o),
        .sda_is_out(sda_is_out),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rd;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t        expq[$];
    ev_t        ev;
    int         n_chk = 0;
    int         n_fail = 0;
    int         pcnt = 0;
    int         scl_hi_pcnt = 0;
    int         lo_half = 30;
    int         hi = 40;
    logic [7:0] mptr = 8'h00;
    logic       prev_strobe = 1'b0;

    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_speed(input int bit_clk, input int high_clk);
        hi      = high_clk;
        lo_half = (bit_clk - high_clk) / 2;
    endtask

    task automatic scl_set(input logic v);
        scl_m = v;
        if (v) scl_hi_pcnt = pcnt;
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            wait_clk(lo_half);
            sda_m = 1'b1;
            wait_clk(lo_half);
            scl_set(1'b1);
            wait_clk(hi / 2);
        end
        sda_m = 1'b0;
        wait_clk(hi / 2);
        scl_set(1'b0);
    endtask

    task automatic bus_stop();
        wait_clk(lo_half);
        sda_m = 1'b0;
        wait_clk(lo_half);
        scl_set(1'b1);
        wait_clk(hi / 2);
        sda_m = 1'b1;
        wait_clk(hi);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(lo_half);
        sda_m = b;
        wait_clk(lo_half);
        scl_set(1'b1);
        wait_clk(hi);
        scl_set(1'b0);
    endtask

    // Eight data bits, then release SDA and look at the slave's answer
    task automatic write_byte(input logic [7:0] b, input logic exp_nack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_clk(lo_half);
        sda_m = 1'b1;
        wait_clk(lo_half);
        scl_set(1'b1);
        wait_clk(hi / 2);
        chk("ack_level", int'(sda_line), int'(exp_nack));
        chk("ack_drive", int'(sda_is_out), int'(!exp_nack));
        wait_clk(hi - hi / 2);
        scl_set(1'b0);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic master_nack);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(2 * lo_half);
            scl_set(1'b1);
            wait_clk(hi / 2);
            chk("rd_bit", int'(sda_line), int'(exp[i]));
            chk("rd_drive", int'(sda_is_out), 1);
            wait_clk(hi - hi / 2);
            scl_set(1'b0);
        end
        send_bit(master_nack);
    endtask

    // Whole write transaction; the model decides ACKs and which writes must appear
    task automatic do_write(input logic [7:0] a, input logic [7:0] r,
                            input logic [7:0] d [4], input int n);
        logic hit;
        hit = (a[7:1] == 7'h68) && !a[0];
        bus_start();
        chk("busy_start", int'(busy), 1);
        write_byte(a, !hit);
        write_byte(r, !hit);
        if (hit) mptr = r;
        for (int i = 0; i < n; i++) begin
            if (hit) begin
                expq.push_back('{rd: 1'b0, a: mptr, d: d[i]});
                mptr = mptr + 8'd1;
            end
            write_byte(d[i], !hit);
        end
        bus_stop();
        wait_clk(10);
        chk("busy_idle", int'(busy), 0);
        chk("drive_idle", int'(sda_is_out), 0);
    endtask

    // Strobe monitor: every wr_en/rd_en must match the oldest expected event
    always @(negedge clk) begin
        if (prev_strobe) chk("strobe_width", int'(wr_en | rd_en), 0);
        prev_strobe = wr_en | rd_en;
        if (rstn && (wr_en || rd_en)) begin
            if (expq.size() == 0) begin
                chk("unexpected_strobe", int'({wr_en, rd_en}), 0);
            end else begin
                ev = expq.pop_front();
                if (wr_en) begin
                    chk("strobe_is_write", int'(ev.rd), 0);
                    chk("wr_addr", int'(wr_addr), int'(ev.a));
                    chk("wr_data", int'(wr_data), int'(ev.d));
                    chk("wr_en_latency", pcnt - scl_hi_pcnt, 3);
                end else begin
                    chk("strobe_is_read", int'(ev.rd), 1);
                end
            end
        end
    end

    logic [7:0] dv [4];
    logic [7:0] ra;
    int         rn;

    initial begin
        rstn    = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        rd_data = 8'h00;
        wait_clk(5);
        chk("rst_sda_o", int'(sda_o), 1);
        chk("rst_sda_is_out", int'(sda_is_out), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        rstn = 1'b1;
        wait_clk(10);

        // Basic write at the nominal bus rate
        set_speed(500, 200);
        dv = '{8'h5A, 8'h00, 8'h00, 8'h00};
        do_write(8'hD0, 8'h00, dv, 1);

        set_speed(100, 40);
        // Foreign address
        do_write(8'hD2, 8'h00, dv, 0);

        // Pointer wrap
        dv = '{8'h11, 8'h22, 8'h33, 8'h00};
        do_write(8'hD0, 8'hFE, dv, 3);

        // Partial byte cut off by a repeated START
        bus_start();
        write_byte(8'hD0, 1'b0);
        write_byte(8'h10, 1'b0);
        mptr = 8'h10;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_start();
        write_byte(8'hD0, 1'b0);
        write_byte(8'h20, 1'b0);
        mptr = 8'h20;
        expq.push_back('{rd: 1'b0, a: 8'h20, d: 8'h77});
        mptr = 8'h21;
        write_byte(8'h77, 1'b0);
        bus_stop();
        wait_clk(10);
        chk("busy_after_sr", int'(busy), 0);

        // Reset pulse during the 5th bit of data byte 0xA8
        bus_start();
        write_byte(8'hD0, 1'b0);
        write_byte(8'h40, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        wait_clk(lo_half);
        sda_m = 1'b1;
        wait_clk(lo_half);
        scl_set(1'b1);
        wait_clk(hi / 2);
        rstn = 1'b0;
        wait_clk(3);
        chk("mid_rst_sda_o", int'(sda_o), 1);
        chk("mid_rst_sda_is_out", int'(sda_is_out), 0);
        chk("mid_rst_wr_addr", int'(wr_addr), 0);
        chk("mid_rst_wr_data", int'(wr_data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        rstn = 1'b1;
        mptr = 8'h00;
        wait_clk(hi - hi / 2);
        scl_set(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        bus_stop();
        wait_clk(10);
        chk("busy_after_rst", int'(busy), 0);
        dv = '{8'h99, 8'h00, 8'h00, 8'h00};
        do_write(8'hD0, 8'h33, dv, 1);

        // Register write then read request with repeated START
        rd_data = 8'hA5;
        bus_start();
        write_byte(8'hD0, 1'b0);
        write_byte(8'h05, 1'b0);
        mptr = 8'h05;
        bus_start();
`ifdef IICS_READ_EN
        expq.push_back('{rd: 1'b1, a: mptr, d: 8'hA5});
        write_byte(8'hD1, 1'b0);
        read_byte(8'hA5, 1'b1);
`else
        write_byte(8'hD1, 1'b1);
`endif
        bus_stop();
        wait_clk(10);
        chk("read_release", int'(sda_is_out), 0);
        chk("read_busy", int'(busy), 0);

        // Randomised writes, some to foreign addresses
        for (int t = 0; t < 6; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? {7'($urandom), 1'b0} : 8'hD0;
            rn = int'($urandom_range(1, 3));
            for (int j = 0; j < 4; j++) dv[j] = 8'($urandom);
            do_write(ra, 8'($urandom), dv, rn);
        end

        wait_clk(50);
        chk("pending_strobes", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
